// File: rtl/mem_arbiter.sv
// Memory arbiter: round-robin between the instruction-fetch and load/store ports,
// one outstanding downstream transaction at a time, with a response timeout.
module mem_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [31:0]     if_rdata,
  output logic            if_err,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [2:0]      ls_op,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            ls_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_op,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int HI = (XLEN >= 64) ? 32 : 0;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state;
  logic            owner_ls;
  logic            prio_ls;
  logic            lat_we;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [2:0]      lat_op;
  logic [CW-1:0]   cnt;
  logic            in_idle;
  logic            grant_if;
  logic            grant_ls;
  logic            done;
  logic            expire;
  logic [31:0]     fetch_word;

  // LSU wins a tie only when IFU was the most recent winner
  assign in_idle  = rst_n && (state == IDLE);
  assign grant_if = in_idle && if_req && (!ls_req || !prio_ls);
  assign grant_ls = in_idle && ls_req && (!if_req || prio_ls);
  assign if_gnt   = grant_if;
  assign ls_gnt   = grant_ls;

  // A response arriving in the last waiting cycle still beats the timeout
  assign done   = ((state == REQ) && mem_ready && mem_rvalid) ||
                  ((state == RESP) && mem_rvalid);
  assign expire = (state != IDLE) && !done && (cnt == CW'(TIMEOUT - 1));

  assign mem_valid = (state == REQ);
  assign mem_addr  = mem_valid ? lat_addr  : '0;
  assign mem_we    = mem_valid && lat_we;
  assign mem_wdata = mem_valid ? lat_wdata : '0;
  assign mem_op    = mem_valid ? lat_op    : 3'd0;

  assign fetch_word = lat_addr[2] ? mem_rdata[HI +: 32] : mem_rdata[31:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_ls  <= 1'b0;
      prio_ls   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_op    <= 3'd0;
      cnt       <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || grant_ls) begin
            state     <= REQ;
            owner_ls  <= grant_ls;
            prio_ls   <= grant_if;
            lat_addr  <= grant_ls ? ls_addr : if_addr;
            lat_we    <= grant_ls && ls_we;
            lat_wdata <= grant_ls ? ls_wdata : '0;
            lat_op    <= grant_ls ? ls_op : 3'd0;
            cnt       <= '0;
          end
        end
        REQ, RESP: begin
          cnt <= cnt + 1'b1;
          if (done || expire) begin
            state <= IDLE;
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_err    <= expire;
              ls_rdata  <= expire ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_err    <= expire;
              if_rdata  <= expire ? '0 : fetch_word;
            end
          end else if ((state == REQ) && mem_ready) begin
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int XLEN = 64;
  localparam int TMO  = 8;

  logic            clk;
  logic            rst_n;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [31:0]     if_rdata;
  logic            if_err;
  logic            ls_req;
  logic            ls_we;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic [2:0]      ls_op;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [XLEN-1:0] ls_rdata;
  logic            ls_err;
  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [XLEN-1:0] mem_wdata;
  logic [2:0]      mem_op;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: last winner (0 = IFU, 1 = LSU) and the response owed next cycle
  int              last_winner = 1;
  bit              pend;
  int              pend_owner;
  bit              pend_err;
  bit              pend_chk_data;
  logic [63:0]     pend_data;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_op(ls_op),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_op(mem_op), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pickWinner(input bit rq_if, input bit rq_ls);
    int w;
    if (rq_if && rq_ls) w = 1 - last_winner;
    else if (rq_ls)     w = 1;
    else if (rq_if)     w = 0;
    else                w = -1;
    if (w >= 0) last_winner = w;
    return w;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compares the response strobes against whatever the model says is owed this cycle
  task automatic checkPending();
    checkOutput("if_rvalid", if_rvalid, pend && pend_owner == 0);
    checkOutput("ls_rvalid", ls_rvalid, pend && pend_owner == 1);
    checkOutput("if_err", if_err, pend && pend_owner == 0 && pend_err);
    checkOutput("ls_err", ls_err, pend && pend_owner == 1 && pend_err);
    if (pend && pend_chk_data) begin
      if (pend_owner == 0) checkOutput("if_rdata", if_rdata, pend_data);
      else                 checkOutput("ls_rdata", ls_rdata, pend_data);
    end
    pend = 1'b0;
  endtask

  task automatic checkQuiet();
    checkOutput("gnt_busy", {if_gnt, ls_gnt}, 0);
    checkOutput("resp_busy", {if_rvalid, ls_rvalid, if_err, ls_err}, 0);
  endtask

  task automatic idleCycle(input bit stray);
    if_req     = 1'b0;
    ls_req     = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = stray;
    mem_rdata  = rnd64();
    @(negedge clk);
    checkPending();
    checkOutput("gnt_idle", {if_gnt, ls_gnt}, 0);
    checkOutput("mem_valid_idle", mem_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  // One whole transaction: grant cycle, rdy_dly stalled REQ cycles, the ready cycle,
  // then rsp_dly cycles until mem_rvalid (rsp_dly < 0 means no response: timeout)
  task automatic applyStimulus(input bit rq_if, input bit rq_ls, input bit we,
                               input logic [63:0] a_if, input logic [63:0] a_ls,
                               input logic [63:0] wd, input logic [2:0] op,
                               input int rdy_dly, input int rsp_dly,
                               input logic [63:0] data, input bit keep);
    int          win;
    logic [63:0] e_addr;
    bit          e_we;
    if_req     = rq_if;
    ls_req     = rq_ls;
    if_addr    = a_if;
    ls_addr    = a_ls;
    ls_we      = we;
    ls_wdata   = wd;
    ls_op      = op;
    mem_ready  = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = rnd64();
    win        = pickWinner(rq_if, rq_ls);
    e_addr     = (win == 1) ? a_ls : a_if;
    e_we       = (win == 1) && we;
    @(negedge clk);
    checkPending();
    checkOutput("if_gnt", if_gnt, win == 0);
    checkOutput("ls_gnt", ls_gnt, win == 1);
    checkOutput("mem_valid_grant", mem_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    if (!keep) begin
      if_req   = 1'b0;
      ls_req   = 1'b0;
      if_addr  = rnd64();
      ls_addr  = rnd64();
      ls_wdata = rnd64();
      ls_op    = 3'($urandom);
      ls_we    = 1'($urandom);
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      mem_ready  = (k == rdy_dly);
      mem_rvalid = (k == rdy_dly) && (rsp_dly == 0);
      mem_rdata  = mem_rvalid ? data : rnd64();
      @(negedge clk);
      checkOutput("mem_valid_req", mem_valid, 1);
      checkOutput("mem_addr", mem_addr, e_addr);
      checkOutput("mem_we", mem_we, e_we);
      if (win == 1) checkOutput("mem_op", mem_op, op);
      if (e_we) checkOutput("mem_wdata", mem_wdata, wd);
      checkQuiet();
      @(posedge clk); #1;
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    if (rsp_dly < 0) begin
      for (int k = rdy_dly + 1; k < TMO; k++) begin
        mem_rdata = rnd64();
        @(negedge clk);
        checkOutput("mem_valid_resp", mem_valid, 0);
        checkQuiet();
        @(posedge clk); #1;
      end
    end else begin
      for (int k = 1; k <= rsp_dly; k++) begin
        mem_rvalid = (k == rsp_dly);
        mem_rdata  = mem_rvalid ? data : rnd64();
        @(negedge clk);
        checkOutput("mem_valid_resp", mem_valid, 0);
        checkQuiet();
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
    end
    pend          = 1'b1;
    pend_owner    = win;
    pend_err      = (rsp_dly < 0);
    pend_chk_data = !e_we;
    if (rsp_dly < 0)   pend_data = 64'd0;
    else if (win == 1) pend_data = data;
    else               pend_data = e_addr[2] ? {32'd0, data[63:32]} : {32'd0, data[31:0]};
  endtask

  initial begin
    int          rq;
    int          rsp;
    logic [63:0] d;
    rst_n      = 1'b0;
    if_req     = 1'b0;
    ls_req     = 1'b0;
    if_addr    = '0;
    ls_addr    = '0;
    ls_we      = 1'b0;
    ls_wdata   = '0;
    ls_op      = 3'd0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    pend       = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_gnt", {if_gnt, ls_gnt}, 0);
    checkOutput("rst_rvalid", {if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    checkOutput("rst_mem_valid", mem_valid, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_ls_rdata", ls_rdata, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Tie held continuously from reset: IFU, LSU, IFU, LSU
    applyStimulus(1, 1, 0, 64'h1000, 64'h2000, 64'h0, 3'd2, 0, 0, 64'hA, 1);
    applyStimulus(1, 1, 0, 64'h1004, 64'h2008, 64'h0, 3'd2, 1, 1, 64'hB, 1);
    applyStimulus(1, 1, 1, 64'h1008, 64'h2010, 64'h55, 3'd3, 2, 0, 64'hC, 1);
    applyStimulus(1, 1, 0, 64'h100C, 64'h2018, 64'h0, 3'd1, 0, 2, 64'hD, 1);
    idleCycle(0);

    // Single fetch, response two cycles after ready, upper word selected
    applyStimulus(1, 0, 0, 64'h8000_0004, 64'h0, 64'h0, 3'd0, 0, 2,
                  64'h1111_2222_3333_4444, 0);
    // Store with ready delayed three cycles
    applyStimulus(0, 1, 1, 64'h0, 64'h4000_0000, 64'hDEAD_BEEF, 3'd3, 3, 1, 64'h0, 0);
    // Fast path: ready and rvalid together
    applyStimulus(0, 1, 0, 64'h0, 64'h4000_0010, 64'h0, 3'd2, 0, 0, 64'h5, 0);
    // Timeout, then a stray mem_rvalid that must be ignored
    applyStimulus(0, 1, 0, 64'h0, 64'h4000_0020, 64'h0, 3'd2, 0, -1, 64'h0, 0);
    idleCycle(1);
    idleCycle(0);

    // Random transactions
    $display("[TB] random phase");
    for (int n = 0; n < 40; n++) begin
      rq  = $urandom_range(1, 3);
      rsp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      d   = rnd64();
      applyStimulus(rq[0], rq[1], 1'($urandom), rnd64(), rnd64(), rnd64(), 3'($urandom),
                    int'($urandom_range(0, 3)), rsp, d, 0);
    end
    idleCycle(0);

    // Reset while waiting in RESP: no response, IDLE afterwards, IFU wins next tie
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 64'h4000_0100;
    @(negedge clk);
    checkOutput("mr_ls_gnt", ls_gnt, pickWinner(0, 1) == 1);
    @(posedge clk); #1;
    ls_req    = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("mr_mem_valid", mem_valid, 1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h77;
    last_winner = 1;
    @(negedge clk);
    checkOutput("mr_rvalid", {if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    checkOutput("mr_mem_valid_idle", mem_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    applyStimulus(1, 1, 0, 64'h3000, 64'h3800, 64'h0, 3'd2, 0, 1, 64'h99, 0);
    idleCycle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
